// File: rtl/floo_vc_credit_arbiter_pkg.sv
// Shared VC-link helpers: id/credit widths and the legal parameter ranges
// that routers and NIs check before instantiating a multi-VC port.
package floo_vc_credit_arbiter_pkg;

  localparam int unsigned MaxVirtChannels = 8;
  localparam int unsigned MaxCredits      = 15;

  typedef enum logic [1:0] {
    CntHold,
    CntTake,
    CntGive
  } cnt_op_e;

  function automatic int unsigned vc_id_width(int unsigned num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  function automatic int unsigned credit_width(int unsigned num_credits);
    return $clog2(num_credits + 1);
  endfunction

  function automatic bit vc_params_ok(int unsigned num_vc, int unsigned num_credits);
    return (num_vc >= 1) && (num_vc <= MaxVirtChannels) &&
           (num_credits >= 1) && (num_credits <= MaxCredits);
  endfunction

endpackage

// File: rtl/floo_vc_credit_arbiter_counter.sv
// Per-VC credit counter: starts full, take/give move it by one and cancel
// when they coincide; a give at full saturates.
module floo_vc_credit_counter
  import floo_vc_credit_arbiter_pkg::*;
#(
  parameter int unsigned NumCredits = 3,
  localparam int unsigned CntW = credit_width(NumCredits)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            take_i,
  input  logic            give_i,
  output logic [CntW-1:0] count_o,
  output logic            left_o,
  output logic            full_o
);

  logic [CntW-1:0] count_d, count_q;
  cnt_op_e         op;

  always_comb begin
    op = CntHold;
    if (take_i && !give_i) op = CntTake;
    if (give_i && !take_i) op = CntGive;
  end

  always_comb begin
    count_d = count_q;
    case (op)
      CntTake: if (count_q != '0) count_d = count_q - CntW'(1);
      CntGive: if (!full_o)       count_d = count_q + CntW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= CntW'(NumCredits);
    else       count_q <= count_d;
  end

  assign count_o = count_q;
  assign left_o  = (count_q != '0);
  assign full_o  = (count_q == CntW'(NumCredits));

endmodule

// File: rtl/floo_vc_credit_arbiter.sv
// Round-robin, credit-gated VC arbiter onto one physical link, with an
// optional retiming register on the link side.
module floo_vc_credit_arbiter
  import floo_vc_credit_arbiter_pkg::*;
#(
  parameter int unsigned NumVirtChannels = 2,
  parameter int unsigned NumCredits      = 3,
  parameter bit          OutReg          = 1'b1,
  parameter type         flit_t          = logic,
  localparam int unsigned IdW  = vc_id_width(NumVirtChannels),
  localparam int unsigned CntW = credit_width(NumCredits)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumVirtChannels-1:0]            valid_i,
  output logic [NumVirtChannels-1:0]            ready_o,
  input  flit_t [NumVirtChannels-1:0]           data_i,
  output logic                                  valid_o,
  output logic [IdW-1:0]                        vc_id_o,
  output flit_t                                 data_o,
  input  logic [NumVirtChannels-1:0]            credit_i,
  output logic [NumVirtChannels-1:0][CntW-1:0]  credits_o
);

  if (!vc_params_ok(NumVirtChannels, NumCredits)) begin : g_param_err
    $error("floo_vc_credit_arbiter: NumVirtChannels or NumCredits out of range");
  end

  logic [NumVirtChannels-1:0] left, full, take, elig;
  logic [IdW-1:0]             ptr_d, ptr_q, win;
  logic                       gnt, gnt_ok;
  int                         idx;

  for (genvar v = 0; v < NumVirtChannels; v++) begin : g_cnt
    floo_vc_credit_counter #(.NumCredits(NumCredits)) i_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .take_i  (take[v]),
      .give_i  (credit_i[v]),
      .count_o (credits_o[v]),
      .left_o  (left[v]),
      .full_o  (full[v])
    );
  end

  assign elig = valid_i & left;

  // Search ascends from ptr and wraps at NumVirtChannels, not at 2**IdW.
  always_comb begin
    gnt = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < int'(NumVirtChannels); k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= int'(NumVirtChannels)) idx = idx - int'(NumVirtChannels);
      if (!gnt && elig[idx]) begin
        gnt = 1'b1;
        win = IdW'(idx);
      end
    end
  end

  assign gnt_ok = gnt && !rst_i;

  always_comb begin
    ready_o = '0;
    for (int v = 0; v < int'(NumVirtChannels); v++) ready_o[v] = gnt_ok && (win == IdW'(v));
  end

  assign take = valid_i & ready_o;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_ok) ptr_d = (win == IdW'(NumVirtChannels - 1)) ? '0 : win + IdW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  if (OutReg) begin : g_out_reg
    logic           valid_q;
    logic [IdW-1:0] vc_id_q;
    flit_t          data_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
        vc_id_q <= '0;
        data_q  <= '0;
      end else begin
        valid_q <= gnt_ok;
        vc_id_q <= gnt_ok ? win : '0;
        data_q  <= gnt_ok ? data_i[win] : '0;
      end
    end

    assign valid_o = valid_q;
    assign vc_id_o = vc_id_q;
    assign data_o  = data_q;
  end else begin : g_out_comb
    assign valid_o = gnt_ok;
    assign vc_id_o = gnt_ok ? win : '0;
    assign data_o  = gnt_ok ? data_i[win] : '0;
  end

  // A give on a full VC is only legal when a take cancels it.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($onehot0(ready_o));
      for (int v = 0; v < int'(NumVirtChannels); v++) assert (!(credit_i[v] && full[v] && !take[v]));
      if (valid_o) assert (int'(vc_id_o) < int'(NumVirtChannels));
    end
  end

endmodule
